// File: rtl/fp_addsub_pipe_if.sv
// Handshake/bus bundle for fp_addsub_pipe.
//   master: operand source and result consumer (drives in_*, out_ready)
//   slave : the add/sub unit (drives in_ready, out_*)
// W = 1+EXP_W+MAN_W, words packed {sign, exp, man}.
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_overflow;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_zero
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract, 3 stages (align, add, normalise).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset; flushes every in-flight transaction
//   bus    - fp_addsub_pipe_if.slave: in_valid/in_ready/in_a/in_b/in_op operand side,
//            out_valid/out_ready/out_result/out_overflow/out_zero result side
// Configuration macro FP_ADDSUB_ROUND_EN: defined -> round-to-nearest-even on G,R,S;
// undefined -> truncation. Latency and handshake identical in both builds.
// No denormals (exp==0 is zero); inf/NaN encodings are treated as ordinary values.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input logic              clk,
  input logic              rst_n,
  fp_addsub_pipe_if.slave  bus
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = MAN_W + 4;          // hidden + man + G,R,S
  localparam int unsigned SW  = MW + 1;             // plus carry
  localparam int unsigned EW  = EXP_W + 2;          // signed working exponent
  localparam int unsigned LZW = $clog2(MW + 1);

  localparam logic [EXP_W-1:0] ShiftMax = EXP_W'(MAN_W + 3);
  localparam logic [EW-1:0]    ExpMax   = {2'b00, {EXP_W{1'b1}}};

  logic advance;

  // ---------------------------------------------------------------- stage 1: align
  logic               a_sign, b_sign, a_zero, b_zero, swap;
  logic [EXP_W-1:0]   a_exp, b_exp, x_exp, y_exp, dexp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic [W-2:0]       a_mag, b_mag;
  logic               x_sign, y_sign;
  logic [MW-1:0]      x_mant, y_mant, y_al, lost;

  logic               s1_valid_d, s1_valid_q;
  logic               s1_sign_d, s1_sign_q;
  logic               s1_sub_d, s1_sub_q;
  logic [EXP_W-1:0]   s1_exp_d, s1_exp_q;
  logic [MW-1:0]      s1_xm_d, s1_xm_q, s1_ym_d, s1_ym_q;

  always_comb begin
    a_sign = bus.in_a[W-1];
    a_exp  = bus.in_a[W-2 -: EXP_W];
    a_man  = bus.in_a[MAN_W-1:0];
    b_sign = bus.in_b[W-1] ^ bus.in_op;
    b_exp  = bus.in_b[W-2 -: EXP_W];
    b_man  = bus.in_b[MAN_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_mag  = a_zero ? '0 : {a_exp, a_man};
    b_mag  = b_zero ? '0 : {b_exp, b_man};
    swap   = (b_mag > a_mag);

    if (swap) begin
      x_sign = b_sign;
      x_exp  = b_exp;
      x_mant = b_zero ? '0 : {1'b1, b_man, 3'b000};
      y_sign = a_sign;
      y_exp  = a_exp;
      y_mant = a_zero ? '0 : {1'b1, a_man, 3'b000};
    end else begin
      x_sign = a_sign;
      x_exp  = a_exp;
      x_mant = a_zero ? '0 : {1'b1, a_man, 3'b000};
      y_sign = b_sign;
      y_exp  = b_exp;
      y_mant = b_zero ? '0 : {1'b1, b_man, 3'b000};
    end

    dexp = x_exp - y_exp;
    lost = '0;
    if (dexp >= ShiftMax) begin
      // Everything lands below S: only the sticky survives.
      y_al = {{(MW-1){1'b0}}, |y_mant};
    end else begin
      y_al    = y_mant >> dexp;
      lost    = y_mant & ~({MW{1'b1}} << dexp);
      y_al[0] = y_al[0] | (|lost);
    end

    s1_valid_d = bus.in_valid;
    s1_sign_d  = x_sign;
    s1_sub_d   = x_sign ^ y_sign;
    s1_exp_d   = x_exp;
    s1_xm_d    = x_mant;
    s1_ym_d    = y_al;
  end

  // ---------------------------------------------------------------- stage 2: add
  logic [SW-1:0]      sum;
  logic               s2_valid_d, s2_valid_q;
  logic               s2_sign_d, s2_sign_q;
  logic [EXP_W-1:0]   s2_exp_d, s2_exp_q;
  logic [SW-1:0]      s2_sum_d, s2_sum_q;

  always_comb begin
    // X has the larger magnitude, so the difference never goes negative.
    if (s1_sub_q) sum = {1'b0, s1_xm_q} - {1'b0, s1_ym_q};
    else          sum = {1'b0, s1_xm_q} + {1'b0, s1_ym_q};
    s2_valid_d = s1_valid_q;
    s2_sign_d  = (sum == '0) ? 1'b0 : s1_sign_q;
    s2_exp_d   = s1_exp_q;
    s2_sum_d   = sum;
  end

  // ---------------------------------------------------------------- stage 3: normalise
  logic [LZW-1:0]     lzc;
  logic               lz_found;
  logic [MW-1:0]      norm_m;
  logic [EW-1:0]      ne;
  logic [MAN_W-1:0]   man_o;
  logic               unused_bits;
`ifdef FP_ADDSUB_ROUND_EN
  logic               rnd_up;
  logic [MAN_W:0]     man_r;
`endif

  logic               out_valid_d, out_valid_q;
  logic [W-1:0]       out_result_d, out_result_q;
  logic               out_overflow_d, out_overflow_q;
  logic               out_zero_d, out_zero_q;

  always_comb begin
    lzc      = LZW'(MW);
    lz_found = 1'b0;
    for (int i = int'(MW) - 1; i >= 0; i--) begin
      if (!lz_found && s2_sum_q[i]) begin
        lzc      = LZW'(int'(MW) - 1 - i);
        lz_found = 1'b1;
      end
    end

    if (s2_sum_q[SW-1]) begin
      // Carry out: shift right one, the dropped bit folds into sticky.
      norm_m = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      ne     = {2'b00, s2_exp_q} + EW'(1);
    end else begin
      norm_m = s2_sum_q[MW-1:0] << lzc;
      ne     = {2'b00, s2_exp_q} - {{(EW-LZW){1'b0}}, lzc};
    end

`ifdef FP_ADDSUB_ROUND_EN
    rnd_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
    man_r  = {1'b0, norm_m[MW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
    man_o  = man_r[MAN_W-1:0];
    // Round-up carry: mantissa wrapped to 1.000.., bump the exponent.
    if (man_r[MAN_W]) ne = ne + EW'(1);
`else
    man_o  = norm_m[MW-2:3];
`endif
    // Hidden bit and G,R,S are consumed by rounding or simply dropped.
    unused_bits = ^{norm_m[MW-1], norm_m[2:0]};

    out_valid_d    = s2_valid_q;
    out_overflow_d = 1'b0;
    out_zero_d     = 1'b0;
    if (s2_sum_q == '0 || ne[EW-1] || ne == '0) begin
      out_result_d = '0;
      out_zero_d   = 1'b1;
    end else if (ne >= ExpMax) begin
      out_result_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_overflow_d = 1'b1;
    end else begin
      out_result_d = {s2_sign_q, ne[EXP_W-1:0], man_o};
    end
  end

  // ---------------------------------------------------------------- state
  always_comb advance = ~out_valid_q | bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_sub_q       <= 1'b0;
      s1_exp_q       <= '0;
      s1_xm_q        <= '0;
      s1_ym_q        <= '0;
      s2_valid_q     <= 1'b0;
      s2_sign_q      <= 1'b0;
      s2_exp_q       <= '0;
      s2_sum_q       <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
    end else if (advance) begin
      s1_valid_q     <= s1_valid_d;
      s1_sign_q      <= s1_sign_d;
      s1_sub_q       <= s1_sub_d;
      s1_exp_q       <= s1_exp_d;
      s1_xm_q        <= s1_xm_d;
      s1_ym_q        <= s1_ym_d;
      s2_valid_q     <= s2_valid_d;
      s2_sign_q      <= s2_sign_d;
      s2_exp_q       <= s2_exp_d;
      s2_sum_q       <= s2_sum_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
    end
  end

  assign bus.in_ready     = advance;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_zero     = out_zero_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (EXP_W=8, MAN_W=7).
module tb_fp_addsub_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef FP_ADDSUB_ROUND_EN
  localparam logic [15:0] RoundExp = 16'h3F81;
`else
  localparam logic [15:0] RoundExp = 16'h3F80;
`endif

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(7)) bus ();

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_op      = 1'b0;
    bus.out_ready  = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_result !== 16'h0000) begin
      failures++; $display("FAIL reset_out_result got=%h want=0000", bus.out_result);
    end
    checks++;
    if (bus.out_overflow !== 1'b0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b want=00", bus.out_overflow, bus.out_zero);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    step();
  endtask

  task automatic test_vectors();
    logic [15:0] va [12] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h4040, 16'h7F7F, 16'h3F80,
                             16'h4000, 16'h4B00, 16'h00C0, 16'h0040, 16'hC000, 16'h3F80};
    logic [15:0] vb [12] = '{16'h3F80, 16'h3F80, 16'h4000, 16'h3F00, 16'h7F7F, 16'h3BC0,
                             16'hBF80, 16'h3F80, 16'h0080, 16'h3F80, 16'hC000, 16'hBF80};
    logic        vo [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ve [12] = '{16'h4000, 16'h0000, 16'hBF80, 16'h4060, 16'h7F80, RoundExp,
                             16'h3F80, 16'h4B00, 16'h0000, 16'h3F80, 16'hC080, 16'h4000};
    logic        vf [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vz [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = va[i];
      bus.in_b      = vb[i];
      bus.in_op     = vo[i];
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL vec%0d_in_ready got=%b want=1", i, bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 10) begin
        step();
        cyc++;
      end
      checks++;
      if (cyc !== 3) begin
        failures++; $display("FAIL vec%0d_latency got=%0d want=3", i, cyc);
      end
      checks++;
      if (bus.out_result !== ve[i]) begin
        failures++;
        $display("FAIL vec%0d_result %h op%0d %h got=%h want=%h",
                 i, va[i], vo[i], vb[i], bus.out_result, ve[i]);
      end
      checks++;
      if (bus.out_overflow !== vf[i] || bus.out_zero !== vz[i]) begin
        failures++;
        $display("FAIL vec%0d_flags got ovf=%b zero=%b want ovf=%b zero=%b",
                 i, bus.out_overflow, bus.out_zero, vf[i], vz[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bb [8] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080,
                            16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};
    logic [15:0] be [8] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                            16'h40C0, 16'h40E0, 16'h4100, 16'h4110};
    int          sent = 0;
    int          recv = 0;
    int          c = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res = '0;
    while (recv < 8 && c < 60) begin
      bus.out_ready = !(c >= 4 && c <= 8);
      bus.in_valid  = (sent < 8);
      bus.in_a      = 16'h3F80;
      bus.in_b      = (sent < 8) ? bb[sent] : 16'h0000;
      bus.in_op     = 1'b0;
      #1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== prev_res) begin
          failures++;
          $display("FAIL b2b_stall_stable c=%0d got=%b/%h want=1/%h",
                   c, bus.out_valid, bus.out_result, prev_res);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++; $display("FAIL b2b_in_ready_stall c=%0d got=%b want=0", c, bus.in_ready);
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) sent++;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (bus.out_result !== be[recv]) begin
          failures++;
          $display("FAIL b2b_result%0d got=%h want=%h", recv, bus.out_result, be[recv]);
        end
        recv++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      step();
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (recv !== 8) begin
      failures++; $display("FAIL b2b_count got=%0d want=8", recv);
    end
    // Throughput: 8 results plus 5 stall cycles plus 3 latency fill.
    checks++;
    if (c > 16) begin
      failures++; $display("FAIL b2b_cycles got=%0d want<=16", c);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_no_duplicate k=%0d got=%b want=0", k, bus.out_valid);
      end
      step();
    end
  endtask

  task automatic test_reset_flush();
    int cyc;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h4040;
    bus.in_b      = 16'h3F00;
    bus.in_op     = 1'b0;
    step();
    bus.in_a      = 16'h3F80;
    bus.in_b      = 16'h4000;
    step();
    bus.in_valid  = 1'b0;
    rst_n         = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_in_ready got=%b want=1", bus.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_stale k=%0d got=%b want=0", k, bus.out_valid);
      end
    end
    // Unit must recover cleanly after the flush.
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h3F80;
    bus.in_b     = 16'h3F80;
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 3 || bus.out_result !== 16'h4000) begin
      failures++;
      $display("FAIL flush_recover got lat=%0d res=%h want lat=3 res=4000", cyc, bus.out_result);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
